// File: rtl/rv_shift_pkg.sv
// Shared types and helpers for the iterative RV shift unit.
package rv_shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_RSV = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nsteps(input int shamt_w, input int step_bits);
    return (shamt_w + step_bits - 1) / step_bits;
  endfunction

endpackage

// File: rtl/rv_shift_step.sv
// One shift step: shifts by (digit << base) as a log-stage barrel over the digit bits.
module rv_shift_step
  import rv_shift_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 2,
  parameter int BASE_W    = 4
) (
  input  logic [XLEN-1:0]      i_data,
  input  logic [STEP_BITS-1:0] i_digit,
  input  logic [BASE_W-1:0]    i_base,
  input  shift_op_e            i_op,
  input  logic                 i_fill,
  output logic [XLEN-1:0]      o_data
);

  localparam logic [XLEN-1:0] ONES = '1;

  logic        w_fill;
  logic [31:0] w_amt;

  // Only SRA replicates the sign; the reserved encoding behaves as SRL.
  assign w_fill = (i_op == SH_SRA) && i_fill;

  always_comb begin
    o_data = i_data;
    w_amt  = '0;
    for (int b = 0; b < STEP_BITS; b++) begin
      w_amt = 32'd1 << (32'(i_base) + 32'(b));
      if (i_digit[b]) begin
        if (i_op == SH_SLL) o_data = o_data << w_amt;
        else o_data = (o_data >> w_amt) | ({XLEN{w_fill}} & ~(ONES >> w_amt));
      end
    end
  end

endmodule

// File: rtl/rv_shift_unit.sv
// Iterative SLL/SRL/SRA unit: retires STEP_BITS shamt bits per cycle, LSB digit first,
// exiting as soon as the remaining digits are zero.
module rv_shift_unit
  import rv_shift_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int SHAMT_W   = $clog2(XLEN),
  parameter int STEP_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output state_e             o_dbg_state
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready, a result on
  // out_valid && out_ready; in_ready is high only in IDLE and out_valid only in DONE, so
  // requests never overlap and a held result is frozen until taken or flushed.

  localparam int NSTEPS = nsteps(SHAMT_W, STEP_BITS);
  localparam int SR_W   = NSTEPS * STEP_BITS;
  localparam int BASE_W = $clog2(SR_W) + 1;

  state_e            r_state, w_next_state;
  logic [XLEN-1:0]   r_acc, r_out_data, w_step;
  logic [SR_W-1:0]   r_shamt;
  logic [BASE_W-1:0] r_base;
  shift_op_e         r_op;
  logic              r_sign;
  logic              w_last, w_accept;

  assign w_last      = (r_shamt >> STEP_BITS) == '0;
  assign w_accept    = (r_state == ST_IDLE) && in_valid && !flush;
  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_data    = r_out_data;
  assign o_dbg_state = r_state;

  rv_shift_step #(
    .XLEN     (XLEN),
    .STEP_BITS(STEP_BITS),
    .BASE_W   (BASE_W)
  ) u_step (
    .i_data (r_acc),
    .i_digit(r_shamt[STEP_BITS-1:0]),
    .i_base (r_base),
    .i_op   (r_op),
    .i_fill (r_sign),
    .o_data (w_step)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next_state = ST_BUSY;
      ST_BUSY: if (w_last) w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_out_data <= '0;
      r_shamt    <= '0;
      r_base     <= '0;
      r_op       <= SH_SLL;
      r_sign     <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= in_data;
      r_shamt <= SR_W'(in_shamt);
      r_base  <= '0;
      r_op    <= shift_op_e'(in_op);
      r_sign  <= in_data[XLEN-1];
    end else if (r_state == ST_BUSY) begin
      r_acc   <= w_step;
      r_shamt <= r_shamt >> STEP_BITS;
      r_base  <= r_base + BASE_W'(STEP_BITS);
      // The visible result only changes when a complete shift finishes.
      if (w_last && !flush) r_out_data <= w_step;
    end
  end

endmodule
